// File: rtl/fetch_unit.sv
// Instruction fetch stage with PC, IF/ID register and branch/jump redirect.
// Define IF_REDIRECT_FLUSH_EN to squash the wrong-path word on a taken redirect.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             Jump,
  input  logic             branchZ,
  input  logic             branchN,
  input  logic             jumpMem,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [WIDTH-1:0] mem_target,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc,
  output logic             id_valid,
  output logic [3:0]       opcode,
  output logic             redirect
);

`ifdef IF_REDIRECT_FLUSH_EN
  typedef enum logic [1:0] {FILL, RUN, BUBBLE} state_e;
`else
  typedef enum logic [1:0] {FILL, RUN} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] idpc_q, idpc_d;
  logic             valid_q, valid_d;
  logic             red_q, red_d;
  logic             taken;
  logic [WIDTH-1:0] target;

  assign taken = Jump | (branchZ & flag_z)
               | (branchN & flag_n);
  assign target = jumpMem ? mem_target
                          : reg_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    valid_d = valid_q;
    red_d   = 1'b0;
    unique case (1'b1)
      taken: begin
        pc_d  = target;
        red_d = 1'b1;
`ifdef IF_REDIRECT_FLUSH_EN
        instr_d = '0;
        valid_d = 1'b0;
        idpc_d  = target;
        state_d = BUBBLE;
`else
        instr_d = imem_rdata;
        valid_d = 1'b1;
        idpc_d  = pc_q;
        state_d = RUN;
`endif
      end
      (stall && !taken): begin
      end
      default: begin
        pc_d    = pc_q + PC_STEP;
        instr_d = imem_rdata;
        idpc_d  = pc_q;
        valid_d = 1'b1;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      idpc_q  <= '0;
      valid_q <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      valid_q <= valid_d;
      red_q   <= red_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_instr  = instr_q;
  assign id_pc     = idpc_q;
  assign id_valid  = valid_q;
  assign opcode    = instr_q[WIDTH-1 -: 4];
  assign redirect  = red_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a rule-level model.
// Flush behaviour of the model follows IF_REDIRECT_FLUSH_EN.
module tb_fetch_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, stall, Jump, branchZ, branchN;
  logic         jumpMem, flag_z, flag_n;
  logic [W-1:0] reg_target, mem_target;
  logic [W-1:0] imem_addr, imem_rdata;
  logic [W-1:0] id_instr, id_pc;
  logic         id_valid, redirect;
  logic [3:0]   opcode;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_pc, m_instr, m_idpc;
  logic         m_valid, m_red;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ (a + 32'h100);
  endfunction

  assign imem_rdata = word(imem_addr);

  fetch_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .Jump(Jump), .branchZ(branchZ),
    .branchN(branchN), .jumpMem(jumpMem),
    .flag_z(flag_z), .flag_n(flag_n),
    .reg_target(reg_target),
    .mem_target(mem_target),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc),
    .id_valid(id_valid), .opcode(opcode),
    .redirect(redirect)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, s, j, bz, bn,
                       input logic jm, fz, fn,
                       input logic [W-1:0] rt, mt);
    rst = r; stall = s; Jump = j;
    branchZ = bz; branchN = bn; jumpMem = jm;
    flag_z = fz; flag_n = fn;
    reg_target = rt; mem_target = mt;
  endtask

  task automatic model_edge();
    logic         tk;
    logic [W-1:0] tg;
    tk = Jump | (branchZ & flag_z) | (branchN & flag_n);
    tg = jumpMem ? mem_target : reg_target;
    if (rst) begin
      m_pc = '0; m_instr = '0; m_idpc = '0;
      m_valid = 0; m_red = 0;
    end else if (tk) begin
      m_red = 1;
`ifdef IF_REDIRECT_FLUSH_EN
      m_instr = '0; m_valid = 0; m_idpc = tg;
`else
      m_instr = word(m_pc); m_valid = 1;
      m_idpc = m_pc;
`endif
      m_pc = tg;
    end else if (stall) begin
      m_red = 0;
    end else begin
      m_instr = word(m_pc); m_idpc = m_pc;
      m_valid = 1; m_red = 0;
      m_pc = m_pc + 1;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc", imem_addr, m_pc);
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_idpc);
    chk("id_valid", id_valid, m_valid);
    chk("opcode", opcode, m_instr[W-1 -: 4]);
    chk("redirect", redirect, m_red);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0,0,0,0,0,0,0,0,'0,'0);
      cyc();
    end
  endtask

  initial begin
    logic [W-1:0] held;
    m_pc = '0; m_instr = '0; m_idpc = '0;
    m_valid = 0; m_red = 0;
    drive(1,0,0,0,0,0,0,0,'0,'0);
    #1;
    cyc();
    cyc();
    chk("rst_pc", imem_addr, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 0);
    seq(1);
    chk("first_idpc", id_pc, 0);
    chk("first_instr", id_instr, word(0));
    seq(4);
    chk("at5", imem_addr, 5);
    held = id_instr;
    for (int i = 0; i < 3; i++) begin
      drive(0,1,0,0,0,0,0,0,'0,'0);
      cyc();
      chk("stall_pc", imem_addr, 5);
      chk("stall_instr", id_instr, held);
    end
    seq(1);
    chk("unstall", imem_addr, 6);
    seq(2);
    drive(0,0,1,0,0,0,0,0,32'h40,32'h99);
    cyc();
    chk("jmp_pc", imem_addr, 32'h40);
    chk("jmp_red", redirect, 1);
`ifdef IF_REDIRECT_FLUSH_EN
    chk("jmp_flush", id_valid, 0);
`else
    chk("jmp_slot", id_instr, word(8));
`endif
    seq(1);
    chk("red_pulse", redirect, 0);
    drive(0,0,0,1,0,1,0,0,'0,32'h7F);
    cyc();
    chk("bz_nt", imem_addr, 32'h42);
    drive(0,0,0,1,0,1,1,0,'0,32'h7F);
    cyc();
    chk("bz_t", imem_addr, 32'h7F);
    drive(0,1,0,0,1,0,0,1,32'h123,'0);
    cyc();
    chk("bn_stall", imem_addr, 32'h123);
    drive(1,1,0,0,1,0,0,1,32'h55,'0);
    cyc();
    chk("rst_win", imem_addr, 0);
    seq(1);
    drive(0,0,1,0,0,0,0,0,32'hFFFF_FFFF,'0);
    cyc();
    seq(2);
    chk("wrap_pc", imem_addr, 1);
    chk("wrap_idpc", id_pc, 0);
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] rt, mt;
      rt = ($urandom_range(3) == 0) ?
           (32'hFFFF_FFFF - $urandom_range(3)) :
           $urandom;
      mt = $urandom;
      drive($urandom_range(63) == 0,
            $urandom_range(3) == 0,
            $urandom_range(15) == 0,
            $urandom_range(5) == 0,
            $urandom_range(5) == 0,
            1'($urandom), 1'($urandom), 1'($urandom),
            rt, mt);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
